// File: rtl/jesd204b_adc_lane_emu.sv
// JESD204B converter-side lane transmitter (ADC emulator).
// CGS -> 4-multiframe ILAS -> scrambled/replaced I/Q data, LMFC aligned to SYSREF.
module jesd204b_adc_lane_emu #(
    parameter int          K_FRAMES     = 32,
    parameter int          SYNC_ERR_LEN = 5,
    parameter logic [14:0] SCR_SEED     = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sysref,
    input  logic        sync_b,
    input  logic        scrambler_is_on,
    input  logic [15:0] tx_data_i,
    input  logic [15:0] tx_data_q,
    output logic [35:0] bus_link_layer,
    output logic [1:0]  state_out,
    output logic [4:0]  lmfc_cnt,
    output logic [7:0]  resync_cnt
);

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [4:0] KM1    = 5'(K_FRAMES - 1);
    localparam logic [7:0] ERR_M1 = 8'(SYNC_ERR_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic        sysref_d;
    logic        sr_edge;
    logic [4:0]  lmfc_eff;
    logic [14:0] scr;
    logic [14:0] scr_nxt;
    logic        scr_en;
    logic [31:0] din;
    logic [31:0] sd;
    logic [4:0]  ilas_f;
    logic [1:0]  ilas_m;
    logic [7:0]  ramp;
    logic        ilas_last;
    logic [7:0]  prev3;
    logic [7:0]  low_cnt;
    logic        err;
    logic [35:0] frame;
    logic [7:0]  o3;

    assign din       = {tx_data_i, tx_data_q};
    assign sr_edge   = sysref & ~sysref_d;
    // An edge makes the current cycle frame 0 of the multiframe.
    assign lmfc_eff  = sr_edge ? 5'd0 : lmfc_cnt;
    assign err       = (state != CGS) && !sync_b && (low_cnt == ERR_M1);
    assign ilas_last = (ilas_m == 2'd3) && (ilas_f == KM1);
    assign state_out = state;

    // Self-synchronous 1+x^14+x^15 scrambler, MSB first over the frame.
    always_comb begin
        scr_nxt = scr;
        sd      = '0;
        for (int i = 31; i >= 0; i--) begin
            sd[i]   = din[i] ^ scr_nxt[13] ^ scr_nxt[14];
            scr_nxt = {scr_nxt[13:0], sd[i]};
        end
    end

    // Next-state decode and frame assembly for the registered output.
    always_comb begin
        state_nxt = state;
        frame     = '0;
        o3        = '0;
        unique case (state)
            CGS: begin
                frame = {32'hBCBC_BCBC, 4'hF};
                if (sync_b && lmfc_eff == KM1)
                    state_nxt = ILAS;
            end
            ILAS: begin
                frame = {ramp, ramp + 8'd1, ramp + 8'd2, ramp + 8'd3, 4'h0};
                if (ilas_f == 5'd0) begin
                    frame[35:28] = 8'h1C;
                    frame[3]     = 1'b1;
                end
                if (ilas_m == 2'd1 && ilas_f == 5'd0) begin
                    frame[27:20] = 8'h9C;
                    frame[2]     = 1'b1;
                end
                if (ilas_f == KM1) begin
                    frame[11:4] = 8'h7C;
                    frame[0]    = 1'b1;
                end
                if (ilas_last)
                    state_nxt = DATA;
            end
            DATA: begin
                frame[35:4] = scr_en ? sd : din;
                o3          = frame[11:4];
                if (scr_en) begin
                    if ((o3 == 8'h7C && lmfc_eff == KM1) ||
                        (o3 == 8'hFC && lmfc_eff != KM1))
                        frame[0] = 1'b1;
                end else if (o3 == prev3) begin
                    frame[11:4] = (lmfc_eff == KM1) ? 8'h7C : 8'hFC;
                    frame[0]    = 1'b1;
                end
            end
            default: state_nxt = CGS;
        endcase
        if (err)
            state_nxt = CGS;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= CGS;
        else
            state <= state_nxt;
    end

    // LMFC counter with SYSREF edge realignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sysref_d <= 1'b0;
            lmfc_cnt <= '0;
        end else begin
            sysref_d <= sysref;
            if (sr_edge)
                lmfc_cnt <= 5'd1;
            else if (lmfc_cnt == KM1)
                lmfc_cnt <= '0;
            else
                lmfc_cnt <= lmfc_cnt + 5'd1;
        end
    end

    // Registered lane output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus_link_layer <= '0;
        else
            bus_link_layer <= frame;
    end

    // Scrambler state and enable; enable is captured only during CGS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scr    <= SCR_SEED;
            scr_en <= 1'b0;
        end else begin
            if (state == CGS)
                scr_en <= scrambler_is_on;
            if (state == CGS || err)
                scr <= SCR_SEED;
            else if (state == DATA && scr_en)
                scr <= scr_nxt;
        end
    end

    // ILAS frame/multiframe position and octet ramp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ilas_f <= '0;
            ilas_m <= '0;
            ramp   <= '0;
        end else if (state != ILAS || err) begin
            ilas_f <= '0;
            ilas_m <= '0;
            ramp   <= '0;
        end else begin
            ramp <= ramp + 8'd4;
            if (ilas_f == KM1) begin
                ilas_f <= '0;
                ilas_m <= ilas_m + 2'd1;
            end else begin
                ilas_f <= ilas_f + 5'd1;
            end
        end
    end

    // Previous pre-replacement octet3; zero ahead of the first data frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev3 <= '0;
        else if (state != DATA)
            prev3 <= '0;
        else
            prev3 <= scr_en ? sd[7:0] : din[7:0];
    end

    // SYNC~ low run length and resync fallback counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_cnt    <= '0;
            resync_cnt <= '0;
        end else begin
            if (state == CGS || sync_b || err)
                low_cnt <= '0;
            else
                low_cnt <= low_cnt + 8'd1;
            if (err && resync_cnt != 8'hFF)
                resync_cnt <= resync_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_jesd204b_adc_lane_emu.sv
// Randomized bench for jesd204b_adc_lane_emu against a frame-level model.
// Model works from ILAS frame numbers and a scrambled-bit history queue.
module tb_jesd204b_adc_lane_emu;

    localparam int K   = 32;
    localparam int LEN = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        sysref;
    logic        sync_b;
    logic        scrambler_is_on;
    logic [15:0] tx_data_i;
    logic [15:0] tx_data_q;
    logic [35:0] bus_link_layer;
    logic [1:0]  state_out;
    logic [4:0]  lmfc_cnt;
    logic [7:0]  resync_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    jesd204b_adc_lane_emu #(
        .K_FRAMES    (K),
        .SYNC_ERR_LEN(LEN),
        .SCR_SEED    (15'h7FFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sysref         (sysref),
        .sync_b         (sync_b),
        .scrambler_is_on(scrambler_is_on),
        .tx_data_i      (tx_data_i),
        .tx_data_q      (tx_data_q),
        .bus_link_layer (bus_link_layer),
        .state_out      (state_out),
        .lmfc_cnt       (lmfc_cnt),
        .resync_cnt     (resync_cnt)
    );

    always #5 clk = ~clk;

    // model state
    int          ms;
    int          mlmfc;
    int          milas;
    int          mlow;
    int          mres;
    bit          msysp;
    bit          mscr;
    logic [7:0]  mprev3;
    logic [35:0] mbus;
    bit          mq[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void seed_q();
        mq = {};
        repeat (15) mq.push_back(1'b1);
    endfunction

    function automatic void model_reset();
        ms = 0; mlmfc = 0; milas = 0; mlow = 0; mres = 0;
        msysp = 0; mscr = 0; mprev3 = 0; mbus = '0;
        seed_q();
    endfunction

    function automatic void model_cycle();
        bit         redge;
        int         eff;
        int         n, f, m, r;
        logic [7:0] o[4];
        logic [3:0] k;
        logic [31:0] d;
        bit         b;
        bit         err;
        redge = sysref && !msysp;
        eff   = redge ? 0 : mlmfc;
        k     = 4'h0;
        for (int j = 0; j < 4; j++) o[j] = 8'hBC;
        if (ms == 0) begin
            k = 4'hF;
        end else if (ms == 1) begin
            n = milas; f = n % K; m = n / K; r = (4 * n) % 256;
            for (int j = 0; j < 4; j++) o[j] = 8'((r + j) % 256);
            if (f == 0) begin o[0] = 8'h1C; k[3] = 1'b1; end
            if (m == 1 && f == 0) begin o[1] = 8'h9C; k[2] = 1'b1; end
            if (f == K - 1) begin o[3] = 8'h7C; k[0] = 1'b1; end
        end else begin
            d = {tx_data_i, tx_data_q};
            if (mscr) begin
                for (int j = 31; j >= 0; j--) begin
                    b = d[j] ^ mq[mq.size() - 14] ^ mq[mq.size() - 15];
                    d[j] = b;
                    mq.push_back(b);
                    void'(mq.pop_front());
                end
            end
            o[0] = d[31:24]; o[1] = d[23:16]; o[2] = d[15:8]; o[3] = d[7:0];
            if (mscr) begin
                if ((o[3] == 8'h7C && eff == K - 1) ||
                    (o[3] == 8'hFC && eff != K - 1))
                    k[0] = 1'b1;
            end else if (o[3] == mprev3) begin
                o[3] = (eff == K - 1) ? 8'h7C : 8'hFC;
                k[0] = 1'b1;
            end
            mprev3 = d[7:0];
        end
        mbus = {o[0], o[1], o[2], o[3], k};
        err = 0;
        if (ms != 0) begin
            mlow = sync_b ? 0 : mlow + 1;
            err  = (mlow == LEN);
        end else begin
            mlow = 0;
        end
        if (err) begin
            ms = 0; mlow = 0; milas = 0;
            if (mres < 255) mres++;
            seed_q();
        end else if (ms == 0) begin
            mscr = scrambler_is_on;
            seed_q();
            if (sync_b && eff == K - 1) begin ms = 1; milas = 0; end
        end else if (ms == 1) begin
            milas++;
            if (milas == 4 * K) begin ms = 2; mprev3 = 8'h00; end
        end
        mlmfc = redge ? 1 : (mlmfc + 1) % K;
        msysp = sysref;
    endfunction

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("bus", bus_link_layer, mbus);
        chk("state", state_out, ms);
        chk("lmfc", lmfc_cnt, mlmfc);
        chk("resync", resync_cnt, mres);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int target, input int max);
        for (int c = 0; c < max && ms != target; c++) step();
        chk("reach_state", state_out, target);
    endtask

    task automatic wait_lmfc(input int v, input int max);
        for (int c = 0; c < max && mlmfc != v; c++) step();
        chk("reach_lmfc", lmfc_cnt, v);
    endtask

    initial begin
        reset = 1'b1; sysref = 1'b0; sync_b = 1'b0;
        scrambler_is_on = 1'b0; tx_data_i = '0; tx_data_q = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus", bus_link_layer, 36'h0);
        chk("rst_state", state_out, 2'd0);
        chk("rst_lmfc", lmfc_cnt, 5'd0);
        chk("rst_resync", resync_cnt, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // CGS with sysref realign, sysref held high for a while
        repeat (5) begin tx_data_i = 16'($urandom); step(); end
        sysref = 1'b1;
        run(3);
        sysref = 1'b0;
        run(40);

        // CGS exit mid-multiframe waits for the boundary; held I/Q, no scrambling
        wait_lmfc(10, 64);
        sync_b = 1'b1;
        tx_data_i = 16'h1234; tx_data_q = 16'h5678;
        run_until(1, 64);
        run_until(2, 4 * K + 4);
        run(80);
        repeat (60) begin
            tx_data_i = 16'($urandom);
            tx_data_q = {8'($urandom), 8'($urandom_range(0, 1))};
            step();
        end

        // SYNC~ glitch of 4 is ignored, 5 forces fallback
        sync_b = 1'b0; run(4);
        sync_b = 1'b1; run(3);
        sync_b = 1'b0; run(5);
        run(2);

        // sysref edge on the exit boundary: realign wins
        scrambler_is_on = 1'b1;
        tx_data_i = '0; tx_data_q = '0;
        wait_lmfc(K - 1, 64);
        sync_b = 1'b1; sysref = 1'b1;
        step();
        sysref = 1'b0;
        run_until(1, 64);
        run_until(2, 4 * K + 4);
        run(256);
        repeat (100) begin
            tx_data_i = 16'($urandom); tx_data_q = 16'($urandom);
            sysref = ($urandom_range(0, 40) == 0);
            step();
        end
        sysref = 1'b0;

        // fallback from DATA, back into ILAS, then async reset mid-ILAS
        sync_b = 1'b0; run(5);
        sync_b = 1'b1;
        run_until(1, 64);
        run(20);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_bus", bus_link_layer, 36'h0);
        chk("arst_state", state_out, 2'd0);
        chk("arst_lmfc", lmfc_cnt, 5'd0);
        chk("arst_resync", resync_cnt, 8'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sync_b = 1'b0; scrambler_is_on = 1'b0;
        run(10);
        sync_b = 1'b1;
        run_until(1, 64);
        run_until(2, 4 * K + 4);
        repeat (20) begin
            tx_data_i = 16'($urandom); tx_data_q = 16'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
